program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
  clk  in  1  system clock; all state changes on its rising edge
  rst  in  1  asynchronous, active-high reset
  start  in  1  begin a 16-byte load session; sampled in IDLE only
  ui_in  in  8  external program byte
  byte_valid  in  1  ui_in holds a valid byte
  byte_ack  out  1  one-cycle pulse: ui_in captured
  ready  in  1  from sequencer: T0 of an instruction pass
  read_ui_in  in  1  from sequencer: drive program byte onto bus now
  done_load  in  1  from sequencer: byte written into RAM this pass
  programming  out  1  to sequencer: passes run as RAM-load passes
  bus_out  out  8  byte driven toward the memory-data register
  bus_en  out  1  bus_out valid (combinational copy of read_ui_in while programming)
  load_count  out  4  bytes committed in this session
  load_done  out  1  session complete, level until next start
  underrun  out  1  sticky: read_ui_in arrived with empty buffer
  checksum  out  8  running byte sum (see Configuration)
REQ-002 Clock and reset SHALL be exactly as above: one clock, asynchronous active-high reset.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, DRAIN, DONE.
REQ-004 IDLE: start=1 -> LOAD; clear load_count, underrun, checksum, buffer; deassert load_done.
REQ-005 LOAD/DRAIN: programming SHALL be 1; IDLE/DONE: 0.
REQ-006 A 1-entry buffer SHALL hold the next byte; when empty and byte_valid=1 in LOAD, capture ui_in, set full, pulse byte_ack for that cycle.
REQ-007 No bypass: byte_ack SHALL NOT assert in a cycle that starts with the buffer full, even if done_load frees it that cycle.
REQ-008 bus_out SHALL equal buffer contents when full, 0x00 when empty; bus_en = read_ui_in AND programming.
REQ-009 read_ui_in=1 with buffer empty SHALL set underrun (sticky); byte 0x00 is loaded and counted.
REQ-010 done_load=1 SHALL empty the buffer, increment load_count mod 16, add committed byte to checksum mod 256.
REQ-011 done_load on the 16th byte (load_count 15 -> 0) SHALL move LOAD -> DRAIN; byte_ack SHALL not assert in DRAIN.
REQ-012 DRAIN SHALL hold programming=1 until a cycle with ready=1, then on that edge go to DONE (programming 0, load_done 1); programming SHALL only fall at a ready edge.
REQ-013 DONE: start=1 SHALL behave as in IDLE (new session); otherwise hold.
REQ-014 start SHALL be ignored in LOAD and DRAIN.
REQ-015 done_load or read_ui_in outside LOAD/DRAIN SHALL have no effect.

Reset
REQ-016 rst=1 SHALL immediately force IDLE, programming 0, byte_ack 0, bus_en 0, bus_out 0x00, load_count 0, load_done 0, underrun 0, checksum 0x00, buffer empty.
REQ-017 Reset mid-session SHALL abandon the session; no partial load_done.

Configuration
REQ-018 Macro LOADER_CHECKSUM_EN: defined -> checksum per REQ-010; undefined -> checksum tied 0x00, no accumulator registers.

Verification
REQ-019 Reset during LOAD at load_count=5 -> all outputs reset values immediately, state IDLE.
REQ-020 start, 16 bytes 0x00..0x0F each presented before read_ui_in -> 16 byte_ack, load_count wraps to 0, checksum 0x78, underrun 0, load_done 1.
REQ-021 byte_valid held low at first read_ui_in -> bus_out 0x00, underrun 1, load_count 1 after done_load.
REQ-022 byte_valid=1 with buffer full and done_load same cycle -> no byte_ack that cycle; byte_ack next cycle.
REQ-023 16th done_load with ready arriving 3 cycles later -> programming stays 1 for those 3 cycles, falls on ready edge, load_done 1.
REQ-024 start pulsed during LOAD at load_count=7 -> no effect; load_count continues to 8 on next done_load.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: buffers external program bytes onto the memory-data bus during sequencer RAM-load passes.
// Optional running checksum enabled by defining LOADER_CHECKSUM_EN.
module program_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] ui_in,
  input  logic       byte_valid,
  output logic       byte_ack,
  input  logic       ready,
  input  logic       read_ui_in,
  input  logic       done_load,
  output logic       programming,
  output logic [7:0] bus_out,
  output logic       bus_en,
  output logic [3:0] load_count,
  output logic       load_done,
  output logic       underrun,
  output logic [7:0] checksum
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state;
  logic full;
  logic [7:0] data_q;
  logic begin_s, capture, commit;
  assign begin_s = start && (state == IDLE || state == DONE);
  assign capture = state == LOAD && !full && byte_valid;
  assign commit = programming && done_load;
  assign byte_ack = capture;
  assign bus_out = full ? data_q : 8'h00;
  assign bus_en = read_ui_in && programming;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      programming <= 1'b0;
      full <= 1'b0;
      data_q <= 8'h00;
      load_count <= 4'd0;
      load_done <= 1'b0;
      underrun <= 1'b0;
    end else if (begin_s) begin
      state <= LOAD;
      programming <= 1'b1;
      full <= 1'b0;
      data_q <= 8'h00;
      load_count <= 4'd0;
      load_done <= 1'b0;
      underrun <= 1'b0;
    end else if (programming) begin
      // a fresh capture wins over the commit freeing an (empty) buffer
      if (capture) begin
        data_q <= ui_in;
        full <= 1'b1;
      end else if (done_load) begin
        full <= 1'b0;
      end
      if (read_ui_in && !full)
        underrun <= 1'b1;
      if (done_load)
        load_count <= load_count + 4'd1;
      if (state == LOAD && done_load && load_count == 4'd15)
        state <= DRAIN;
      if (state == DRAIN && ready) begin
        state <= DONE;
        programming <= 1'b0;
        load_done <= 1'b1;
      end
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  assign checksum = sum_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sum_q <= 8'h00;
    else if (begin_s)
      sum_q <= 8'h00;
    else if (commit)
      sum_q <= sum_q + bus_out;
  end
`else
  logic unused_commit;
  assign unused_commit = commit;
  assign checksum = 8'h00;
`endif
endmodule
